// File: rtl/pipe_stage_ctrl_if.sv
// Handshake, control and observation bundle for pipe_stage_ctrl.
// master drives the instruction stream and per-stage requests; slave is the pipeline controller.
interface pipe_stage_ctrl_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 3
);
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic [REG_AW-1:0]          in_dst;
    logic                       in_wen;
    logic                       in_ready;
    logic [STAGES-1:0]          stall_req;
    logic [STAGES-1:0]          flush_req;
    logic [STAGES-1:0]          stage_valid;
    logic [STAGES*DATA_W-1:0]   stage_data;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [REG_AW-1:0]          src_a;
    logic [REG_AW-1:0]          src_b;
    logic [STAGES-1:0]          fwd_a_sel;
    logic [STAGES-1:0]          fwd_b_sel;

    modport master (
        output in_valid, in_data, in_dst, in_wen, stall_req, flush_req, src_a, src_b,
        input  in_ready, stage_valid, stage_data, out_valid, out_data, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  in_valid, in_data, in_dst, in_wen, stall_req, flush_req, src_a, src_b,
        output in_ready, stage_valid, stage_data, out_valid, out_data, fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Pipeline-register chain with centralised stall, bubble, flush and forwarding lookup.
// Optional PIPE_STAGE_CTRL_PERF_EN adds saturating stall/flush event counters.
module pipe_stage_ctrl #(
    parameter int unsigned       STAGES = 4,
    parameter int unsigned       DATA_W = 64,
    parameter int unsigned       REG_AW = 3,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_ctrl_if.slave  bus
`ifdef PIPE_STAGE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] data;
    } stage_t;

    localparam stage_t EMPTY = '{valid: 1'b0, wen: 1'b0, dst: '0, data: BUBBLE};

    stage_t            st_q [STAGES];
    stage_t            st_d [STAGES];
    stage_t            prev [STAGES];
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] stall_prev;
    logic [STAGES-1:0] valid_vec;

    // A stall freezes itself and everything younger; a flush kills everything younger.
    always_comb begin
        hold = '0;
        kill = '0;
        for (int k = 0; k < STAGES; k++) begin
            for (int j = k; j < STAGES; j++)
                hold[k] = hold[k] | bus.stall_req[j];
            for (int j = k + 1; j < STAGES; j++)
                kill[k] = kill[k] | bus.flush_req[j];
        end
    end

    assign stall_prev = {bus.stall_req[STAGES-2:0], 1'b0};

    // Upstream source for each stage; an idle input slot enters as a bubble.
    always_comb begin
        for (int k = 0; k < STAGES; k++)
            prev[k] = EMPTY;
        if (bus.in_valid)
            prev[0] = '{valid: 1'b1, wen: bus.in_wen, dst: bus.in_dst, data: bus.in_data};
        for (int k = 1; k < STAGES; k++)
            prev[k] = st_q[k-1];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = prev[k];
            if (kill[k])
                st_d[k] = EMPTY;
            else if (hold[k])
                st_d[k] = st_q[k];
            else if (stall_prev[k])
                st_d[k] = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++)
                st_q[k] <= EMPTY;
        end else begin
            for (int k = 0; k < STAGES; k++)
                st_q[k] <= st_d[k];
        end
    end

    always_comb begin
        valid_vec      = '0;
        bus.stage_data = '0;
        for (int k = 0; k < STAGES; k++) begin
            valid_vec[k]                           = st_q[k].valid;
            bus.stage_data[k*DATA_W +: DATA_W]     = st_q[k].data;
        end
    end

    assign bus.stage_valid = valid_vec;
    assign bus.out_valid   = st_q[STAGES-1].valid;
    assign bus.out_data    = st_q[STAGES-1].data;
    assign bus.in_ready    = ~hold[0] | kill[0];

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        bus.fwd_a_sel = '0;
        bus.fwd_b_sel = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (st_q[k].valid && st_q[k].wen && (st_q[k].dst == bus.src_a))
                bus.fwd_a_sel = STAGES'(1) << k;
            if (st_q[k].valid && st_q[k].wen && (st_q[k].dst == bus.src_b))
                bus.fwd_b_sel = STAGES'(1) << k;
        end
    end

`ifdef PIPE_STAGE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((|bus.stall_req) && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((|(kill & valid_vec)) && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
